// File: rtl/seq_mult_cla.sv
// rtl/seq_mult_cla.sv - sequential shift-add multiplier, WIDTH iterations per product
// Define SIGNED_MULT_EN for two's-complement operands via radix-2 Booth recoding.
module seq_mult_cla #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;
`ifdef SIGNED_MULT_EN
  logic               qm1_q, qm1_d;
`endif

  // One adder slice, one bit wider than the operands so the carry/sign survives the shift.
  always_comb begin
`ifdef SIGNED_MULT_EN
    case ({q_q[0], qm1_q})
      2'b01:   sum = {acc_q[WIDTH-1], acc_q} + {m_q[WIDTH-1], m_q};
      2'b10:   sum = {acc_q[WIDTH-1], acc_q} + ~{m_q[WIDTH-1], m_q} + {{WIDTH{1'b0}}, 1'b1};
      default: sum = {acc_q[WIDTH-1], acc_q};
    endcase
`else
    sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SIGNED_MULT_EN
    qm1_d     = qm1_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SIGNED_MULT_EN
          qm1_d   = 1'b0;
`endif
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
`ifdef SIGNED_MULT_EN
        qm1_d = q_q[0];
`endif
        if (cnt_q == CNT_LAST) begin
          product_d = {acc_d, q_d};
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SIGNED_MULT_EN
      qm1_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SIGNED_MULT_EN
      qm1_q     <= qm1_d;
`endif
    end
  end

  assign Busy    = (state_q == S_RUN);
  assign Done    = (state_q == S_DONE);
  assign Product = product_q;

endmodule

// File: tb/tb_seq_mult_cla.sv
// tb/tb_seq_mult_cla.sv - directed and random checks of seq_mult_cla at WIDTH=8 and WIDTH=16
module tb_seq_mult_cla;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8, done8, busy16, done16;
    logic [15:0] product8;
    logic [31:0] product16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mult_cla #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(start8), .A(a8), .B(b8),
        .Busy(busy8), .Done(done8), .Product(product8)
    );

    seq_mult_cla #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .Start(start16), .A(a16), .B(b16),
        .Busy(busy16), .Done(done16), .Product(product16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        longint p;
`ifdef SIGNED_MULT_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
        longint p;
`ifdef SIGNED_MULT_EN
        p = longint'($signed(a)) * longint'($signed(b));
`else
        p = longint'(a) * longint'(b);
`endif
        return p[31:0];
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check({tag, "_busy0"}, 64'(busy8), 64'(1'b1));
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check({tag, "_busy"}, 64'({busy8, done8}), 64'(2'b10));
        end
        @(posedge clk); #1;
        check({tag, "_done"}, 64'({busy8, done8}), 64'(2'b01));
        check({tag, "_product"}, 64'(product8), 64'(ref8(a, b)));
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input string tag);
        @(negedge clk);
        a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_busy_end"}, 64'({busy16, done16}), 64'(2'b10));
        @(posedge clk); #1;
        check({tag, "_done"}, 64'({busy16, done16}), 64'(2'b01));
        check({tag, "_product"}, 64'(product16), 64'(ref16(a, b)));
    endtask

    initial begin
        #200000;
        check("watchdog_expired", 64'd1, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int ndone;
        int done_at [2];
        logic [15:0] prod_at [2];

        #2;
        check("reset8", 64'({busy8, done8, product8}), 64'd0);
        check("reset16", 64'({busy16, done16, product16}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'd13, 8'd11, "t1");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t1_hold", 64'({done8, product8}), 64'({1'b0, ref8(8'd13, 8'd11)}));
        end

        run8(8'd255, 8'd255, "t2a");
        run8(8'd0, 8'd200, "t2b");

        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        for (int n = 4; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                check("t3_product", 64'(product8), 64'(ref8(8'd7, 8'd9)));
            end
        end
        check("t3_done_count", 64'(ndone), 64'd1);

        @(negedge clk);
        a8 = 8'd5; b8 = 8'd6; start8 = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        done_at[0] = 0; done_at[1] = 0;
        prod_at[0] = '0; prod_at[1] = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (ndone < 2) begin
                    done_at[ndone] = n;
                    prod_at[ndone] = product8;
                end
                ndone++;
                if (ndone == 1) begin
                    a8 = 8'd10; b8 = 8'd10;
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        check("t4_done_count", 64'(ndone), 64'd2);
        check("t4_first_at", 64'(done_at[0]), 64'd8);
        check("t4_spacing", 64'(done_at[1] - done_at[0]), 64'd9);
        check("t4_product0", 64'(prod_at[0]), 64'(ref8(8'd5, 8'd6)));
        check("t4_product1", 64'(prod_at[1]), 64'(ref8(8'd10, 8'd10)));

        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_reset8", 64'({busy8, done8, product8}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd2, 8'd3, "t5_after");

        for (int i = 0; i < 10; i++) begin
            run8(8'($urandom), 8'($urandom), "rand8");
        end

        run16(16'hFFFD, 16'd5, "t6a");
`ifdef SIGNED_MULT_EN
        run16(16'h8000, 16'h8000, "t6b");
        check("t6b_const", 64'(product16), 64'(32'h40000000));
`else
        check("t6a_const", 64'(product16), 64'(32'h0004FFF1));
`endif
        for (int i = 0; i < 4; i++) begin
            run16(16'($urandom), 16'($urandom), "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
